// File: rtl/truth_table_sweeper_if.sv
// Host-side control/status bundle for the truth-table sweeper.
interface truth_table_sweeper_if;
  logic       start;
  logic       abort;
  logic [7:0] expected;
  logic       busy;
  logic       done;
  logic [7:0] code;
  logic [7:0] unstable;
  logic       match;

  modport master (
    output start, abort, expected,
    input  busy, done, code, unstable, match
  );

  modport slave (
    input  start, abort, expected,
    output busy, done, code, unstable, match
  );
endinterface

// File: rtl/truth_table_sweeper.sv
// Walks a 3-input circuit through all 8 input rows, samples its synchronized
// output after a settle window and reports the measured truth-table code.
module truth_table_sweeper #(
  parameter int SETTLE_CYCLES = 16,
  parameter int STABLE_CYCLES = 4,
  parameter int CNT_W         = 8
) (
  input  logic                        clk,
  input  logic                        rst_n,
  truth_table_sweeper_if.slave        host,
  input  logic                        dut_out,
  output logic                        in1,
  output logic                        in2,
  output logic                        in3
);

  typedef enum logic [1:0] {IDLE, SETTLE, DONE} state_t;

  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] WIN_START = CNT_W'(SETTLE_CYCLES - STABLE_CYCLES);

  state_t           state_q, state_d;
  logic [2:0]       row_q, row_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]       exp_q, exp_d;
  logic [7:0]       code_q, code_d;
  logic [7:0]       unstable_q, unstable_d;
  logic             match_q, match_d;
  logic             sync1_q, sync1_d;
  logic             dsync_q, dsync_d;
  logic             dprev_q, dprev_d;
  logic [2:0]       bit_idx;

  // Row 000 lands in the MSB of the code.
  assign bit_idx = 3'd7 - row_q;

  always_comb begin
    state_d    = state_q;
    row_d      = row_q;
    cnt_d      = cnt_q;
    exp_d      = exp_q;
    code_d     = code_q;
    unstable_d = unstable_q;
    match_d    = match_q;
    sync1_d    = dut_out;
    dsync_d    = sync1_q;
    dprev_d    = dsync_q;

    case (state_q)
      IDLE: begin
        if (host.start && !host.abort) begin
          state_d    = SETTLE;
          exp_d      = host.expected;
          code_d     = 8'h00;
          unstable_d = 8'h00;
          match_d    = 1'b0;
          row_d      = 3'd0;
          cnt_d      = '0;
        end
      end
      SETTLE: begin
        if (host.abort) begin
          state_d = IDLE;
        end else begin
          if ((cnt_q >= WIN_START) && (dsync_q != dprev_q)) begin
            unstable_d[bit_idx] = 1'b1;
          end
          if (cnt_q == CNT_LAST) begin
            code_d[bit_idx] = dsync_q;
            cnt_d           = '0;
            if (row_q == 3'd7) begin
              state_d = DONE;
              match_d = (code_d == exp_q) && (unstable_d == 8'h00);
            end else begin
              row_d = row_q + 3'd1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      row_q      <= 3'd0;
      cnt_q      <= '0;
      exp_q      <= 8'h00;
      code_q     <= 8'h00;
      unstable_q <= 8'h00;
      match_q    <= 1'b0;
      sync1_q    <= 1'b0;
      dsync_q    <= 1'b0;
      dprev_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      row_q      <= row_d;
      cnt_q      <= cnt_d;
      exp_q      <= exp_d;
      code_q     <= code_d;
      unstable_q <= unstable_d;
      match_q    <= match_d;
      sync1_q    <= sync1_d;
      dsync_q    <= dsync_d;
      dprev_q    <= dprev_d;
    end
  end

  // Circuit inputs follow the row only while sweeping, so abort/done park them at 000.
  assign {in1, in2, in3} = (state_q == SETTLE) ? row_q : 3'b000;
  assign host.busy       = (state_q == SETTLE);
  assign host.done       = (state_q == DONE);
  assign host.code       = code_q;
  assign host.unstable   = unstable_q;
  assign host.match      = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Directed bench for truth_table_sweeper driving a 0x78 gate model (in1 ^ (in2 | in3)).
module tb_truth_table_sweeper;
  localparam int SETTLE = 6;
  localparam int STABLE = 2;
  localparam int SWEEP  = 8 * SETTLE;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic glitch = 1'b0;
  logic dut_out, in1, in2, in3;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  truth_table_sweeper_if host_if ();

  assign dut_out = (in1 ^ (in2 | in3)) ^ glitch;

  truth_table_sweeper #(
    .SETTLE_CYCLES(SETTLE),
    .STABLE_CYCLES(STABLE),
    .CNT_W(8)
  ) u_dut (
    .clk(clk),
    .rst_n(rst_n),
    .host(host_if),
    .dut_out(dut_out),
    .in1(in1),
    .in2(in2),
    .in3(in3)
  );

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  // Start a sweep and follow it cycle by cycle until done or a bounded timeout.
  task automatic run_sweep(input logic [7:0] exp_code, input int glitch_c, input int abort_c,
                           input bit repulse, output int done_c, output int busy_n, output int seq_err);
    logic       want_busy;
    logic [2:0] want_row;
    done_c  = 0;
    busy_n  = 0;
    seq_err = 0;
    host_if.expected = exp_code;
    host_if.start    = 1'b1;
    tick();
    host_if.start    = 1'b0;
    host_if.expected = ~exp_code;
    for (int c = 1; c <= SWEEP + 30; c++) begin
      want_busy = (c <= SWEEP) && (c <= abort_c);
      want_row  = want_busy ? 3'((c - 1) / SETTLE) : 3'd0;
      if (host_if.busy === 1'b1) busy_n++;
      if (host_if.busy !== want_busy || {in1, in2, in3} !== want_row) seq_err++;
      if (host_if.done === 1'b1) begin
        done_c = c;
        break;
      end
      glitch        = (c == glitch_c);
      host_if.abort = (c == abort_c);
      host_if.start = repulse && (c == 5 || c == 20);
      tick();
    end
    glitch        = 1'b0;
    host_if.abort = 1'b0;
    host_if.start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (host_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", host_if.busy); end
    checks++; if (host_if.done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", host_if.done); end
    checks++; if (host_if.code !== 8'h00) begin errors++; $display("FAIL reset_code: got %h want 00", host_if.code); end
    checks++; if (host_if.unstable !== 8'h00) begin errors++; $display("FAIL reset_unstable: got %h want 00", host_if.unstable); end
    checks++; if (host_if.match !== 1'b0) begin errors++; $display("FAIL reset_match: got %b want 0", host_if.match); end
    checks++; if ({in1, in2, in3} !== 3'b000) begin errors++; $display("FAIL reset_inputs: got %b want 000", {in1, in2, in3}); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checks++; if (host_if.busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b want 0", host_if.busy); end
  endtask

  task automatic test_clean_sweep;
    int d, b, s;
    run_sweep(8'h78, -1, 1000, 1'b0, d, b, s);
    checks++; if (d !== 49) begin errors++; $display("FAIL clean_done_cycle: got %0d want 49", d); end
    checks++; if (b !== SWEEP) begin errors++; $display("FAIL clean_busy_cycles: got %0d want %0d", b, SWEEP); end
    checks++; if (s !== 0) begin errors++; $display("FAIL clean_row_sequence: got %0d bad cycles want 0", s); end
    checks++; if (host_if.code !== 8'h78) begin errors++; $display("FAIL clean_code: got %h want 78", host_if.code); end
    checks++; if (host_if.unstable !== 8'h00) begin errors++; $display("FAIL clean_unstable: got %h want 00", host_if.unstable); end
    checks++; if (host_if.match !== 1'b1) begin errors++; $display("FAIL clean_match: got %b want 1", host_if.match); end
    tick();
    checks++; if (host_if.done !== 1'b0) begin errors++; $display("FAIL done_one_cycle: got %b want 0", host_if.done); end
    checks++; if (host_if.match !== 1'b1) begin errors++; $display("FAIL match_held: got %b want 1", host_if.match); end
  endtask

  task automatic test_mismatch;
    int d, b, s;
    run_sweep(8'hE8, -1, 1000, 1'b0, d, b, s);
    checks++; if (d !== 49) begin errors++; $display("FAIL mismatch_done_cycle: got %0d want 49", d); end
    checks++; if (host_if.code !== 8'h78) begin errors++; $display("FAIL mismatch_code: got %h want 78", host_if.code); end
    checks++; if (host_if.match !== 1'b0) begin errors++; $display("FAIL mismatch_match: got %b want 0", host_if.match); end
    tick();
  endtask

  task automatic test_glitch_window;
    int d, b, s;
    // Row 011, cnt=2: reaches dsync at cnt=4, inside the window.
    run_sweep(8'h78, 3 * SETTLE + 3, 1000, 1'b0, d, b, s);
    checks++; if (host_if.unstable !== 8'h10) begin errors++; $display("FAIL glitch_in_unstable: got %h want 10", host_if.unstable); end
    checks++; if (host_if.code !== 8'h78) begin errors++; $display("FAIL glitch_in_code: got %h want 78", host_if.code); end
    checks++; if (host_if.match !== 1'b0) begin errors++; $display("FAIL glitch_in_match: got %b want 0", host_if.match); end
    tick();
    // Row 011, cnt=0: settles out of dsync before the window opens.
    run_sweep(8'h78, 3 * SETTLE + 1, 1000, 1'b0, d, b, s);
    checks++; if (host_if.unstable !== 8'h00) begin errors++; $display("FAIL glitch_early_unstable: got %h want 00", host_if.unstable); end
    checks++; if (host_if.match !== 1'b1) begin errors++; $display("FAIL glitch_early_match: got %b want 1", host_if.match); end
    tick();
  endtask

  task automatic test_abort;
    int d, b, s;
    host_if.start = 1'b1;
    host_if.abort = 1'b1;
    tick();
    host_if.start = 1'b0;
    host_if.abort = 1'b0;
    checks++; if (host_if.busy !== 1'b0) begin errors++; $display("FAIL start_abort_same_edge: busy got %b want 0", host_if.busy); end
    // Abort during row 101 (cnt=2).
    run_sweep(8'h78, -1, 5 * SETTLE + 3, 1'b0, d, b, s);
    checks++; if (d !== 0) begin errors++; $display("FAIL abort_no_done: done seen at cycle %0d want none", d); end
    checks++; if (b !== 5 * SETTLE + 3) begin errors++; $display("FAIL abort_busy_cycles: got %0d want %0d", b, 5 * SETTLE + 3); end
    checks++; if (s !== 0) begin errors++; $display("FAIL abort_sequence: got %0d bad cycles want 0", s); end
    checks++; if (host_if.match !== 1'b0) begin errors++; $display("FAIL abort_match: got %b want 0", host_if.match); end
    checks++; if (host_if.code !== 8'h78) begin errors++; $display("FAIL abort_partial_code: got %h want 78", host_if.code); end
    run_sweep(8'h78, -1, 1000, 1'b0, d, b, s);
    checks++; if (d !== 49 || host_if.match !== 1'b1) begin errors++; $display("FAIL after_abort_sweep: done %0d match %b want 49/1", d, host_if.match); end
    tick();
  endtask

  task automatic test_back_to_back;
    int d, b, s;
    run_sweep(8'h78, -1, 1000, 1'b1, d, b, s);
    checks++; if (d !== 49) begin errors++; $display("FAIL restart_ignored_done: got %0d want 49", d); end
    checks++; if (s !== 0) begin errors++; $display("FAIL restart_ignored_sequence: got %0d bad cycles want 0", s); end
    checks++; if (host_if.match !== 1'b1) begin errors++; $display("FAIL restart_ignored_match: got %b want 1", host_if.match); end
    tick();
  endtask

  task automatic test_reset_mid_sweep;
    int d, b, s;
    host_if.expected = 8'h78;
    host_if.start    = 1'b1;
    tick();
    host_if.start    = 1'b0;
    repeat (9) tick();
    #2 rst_n = 1'b0;
    #1;
    checks++; if (host_if.busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b want 0", host_if.busy); end
    checks++; if ({in1, in2, in3} !== 3'b000) begin errors++; $display("FAIL midreset_inputs: got %b want 000", {in1, in2, in3}); end
    checks++; if (host_if.code !== 8'h00) begin errors++; $display("FAIL midreset_code: got %h want 00", host_if.code); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    run_sweep(8'h78, -1, 1000, 1'b0, d, b, s);
    checks++; if (d !== 49) begin errors++; $display("FAIL post_reset_done: got %0d want 49", d); end
    checks++; if (host_if.code !== 8'h78 || host_if.match !== 1'b1) begin errors++; $display("FAIL post_reset_result: code %h match %b want 78/1", host_if.code, host_if.match); end
  endtask

  initial begin
    host_if.start    = 1'b0;
    host_if.abort    = 1'b0;
    host_if.expected = 8'h00;
    test_reset();
    test_clean_sweep();
    test_mismatch();
    test_glitch_window();
    test_abort();
    test_back_to_back();
    test_reset_mid_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
